rr_arbiter4: RTL

//  Round-robin arbiter sharing one downstream resource among 4 requesters.
//  - Emits a one-hot grant plus its 2-bit binary index; the index comes from a one-hot-to-binary encoder.
//  - Each grant is held until the owner drops its request, or until a hold-limit timeout revokes it.
//  - Sits between requesting masters and the shared datapath; gnt_id drives the datapath's source mux select.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/rr_pick4.sv | 46 ++++
 rtl/rr_arbiter4.sv | 136 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the 4-way round-robin arbiter.
//   - N_REQ / REQ_W : requester count and width of a requester index
//   - state_e       : two-state arbiter FSM encoding (ST_IDLE / ST_GRANT)
//   - onehot_to_bin : one-hot to binary index encoder
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int REQ_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // OR-based encoder: for a one-hot input each output bit is the OR of the
  // positions whose index has that bit set. An all-zero input encodes to 0.
  function automatic logic [REQ_W-1:0] onehot_to_bin(input logic [N_REQ-1:0] onehot);
    logic [REQ_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) bin = bin | REQ_W'(i);
    end
    return bin;
  endfunction

endpackage : arb_pkg

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
//   Combinational round-robin pick: the first set request bit found when
//   searching upward from ptr, wrapping 3 -> 0.
// Ports
//   req         in  [3:0]  request vector, bit i = requester i
//   ptr         in  [1:0]  highest-priority position for this search
//   pick_onehot out [3:0]  one-hot winner, zero when req == 0
//   pick_id     out [1:0]  binary index of the winner, zero when req == 0
//   pick_any    out        high when any request is set
// ---------------------------------------------------------------------------
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [REQ_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_onehot,
  output logic [REQ_W-1:0] pick_id,
  output logic             pick_any
);

  logic [2*N_REQ-1:0] w_req_dbl;
  logic [2*N_REQ-1:0] w_req_rot_wide;
  logic [N_REQ-1:0]   w_req_rot;
  logic [N_REQ-1:0]   w_sel_rot;
  logic [2*N_REQ-1:0] w_sel_dbl;
  logic [2*N_REQ-1:0] w_sel_back_wide;

  // Rotate right by ptr so the ptr position lands at bit 0; a plain
  // lowest-bit-first priority then implements the wrapped search.
  assign w_req_dbl      = {req, req};
  assign w_req_rot_wide = w_req_dbl >> ptr;
  assign w_req_rot      = w_req_rot_wide[N_REQ-1:0];

  // Isolate the lowest set bit (two's-complement trick).
  assign w_sel_rot = w_req_rot & (~w_req_rot + N_REQ'(1));

  // Rotate left by ptr to return to requester numbering.
  assign w_sel_dbl       = {w_sel_rot, w_sel_rot};
  assign w_sel_back_wide = w_sel_dbl << ptr;
  assign pick_onehot     = w_sel_back_wide[2*N_REQ-1:N_REQ];

  assign pick_id  = onehot_to_bin(pick_onehot);
  assign pick_any = |req;

endmodule : rr_pick4

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
//   Round-robin arbiter sharing one downstream resource among 4 requesters.
//   A grant is held until its owner drops the request or until it has been
//   held MAX_HOLD cycles. Every grant is followed by at least one idle cycle
//   with gnt == 0 so the datapath source mux switches cleanly.
// Parameters
//   MAX_HOLD       maximum consecutive cycles one owner may hold the grant
// Ports
//   clk            in        rising-edge clock
//   rst_n          in        synchronous active-low reset
//   req            in  [3:0] request per requester
//   gnt            out [3:0] registered one-hot grant, zero when no owner
//   gnt_id         out [1:0] binary index of the owner, zero when gnt == 0
//   gnt_valid      out       high iff gnt != 0
//   timeout_pulse  out       one-cycle pulse after a hold-limit revocation
// ---------------------------------------------------------------------------
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [REQ_W-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout_pulse
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be at least 1");
  end

  state_e            r_state;
  logic [REQ_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [N_REQ-1:0]  r_gnt;
  logic [REQ_W-1:0]  r_gnt_id;
  logic              r_timeout;

  state_e            w_state_nxt;
  logic [REQ_W-1:0]  w_ptr_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic [N_REQ-1:0]  w_gnt_nxt;
  logic [REQ_W-1:0]  w_gnt_id_nxt;
  logic              w_timeout_nxt;

  logic [N_REQ-1:0]  w_pick_onehot;
  logic [REQ_W-1:0]  w_pick_id;
  logic              w_pick_any;
  logic              w_owner_req;

  rr_pick4 u_pick (
    .req         (req),
    .ptr         (r_ptr),
    .pick_onehot (w_pick_onehot),
    .pick_id     (w_pick_id),
    .pick_any    (w_pick_any)
  );

  // Owner still requesting; only the owner's bit matters during GRANT.
  assign w_owner_req = |(req & r_gnt);

  // NOTE: every output is given a default before the case so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_timeout_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt    = ST_GRANT;
          w_gnt_nxt      = w_pick_onehot;
          w_gnt_id_nxt   = w_pick_id;
          w_ptr_nxt      = w_pick_id + REQ_W'(1);
          w_hold_cnt_nxt = '0;
        end
      end

      ST_GRANT: begin
        if (!w_owner_req || (r_hold_cnt == HOLD_LAST)) begin
          // Release takes precedence: the pulse fires only when the owner
          // was still requesting at the limit.
          w_state_nxt    = ST_IDLE;
          w_gnt_nxt      = '0;
          w_gnt_id_nxt   = '0;
          w_hold_cnt_nxt = '0;
          w_timeout_nxt  = w_owner_req;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers
  // sample the same pre-edge values; reset is a synchronous branch here,
  // clearing every register including a grant in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign gnt           = r_gnt;
  assign gnt_id        = r_gnt_id;
  assign gnt_valid     = |r_gnt;
  assign timeout_pulse = r_timeout;

endmodule : rr_arbiter4
